// File: rtl/adc_measure_responder.sv
// Multislope ADC conversion responder: integrator reset, fixed-aperture run-up, rundown,
// then a single-cycle done with latched counts.
module adc_measure_responder #(
   parameter int RESET_CLKS  = 1000,
   parameter int RUNUP_CYCLE = 20,
   parameter int APER_CYCLES = 10000,
   parameter int RUNDOWN_MAX = 4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        adc_measure_start,
   input  logic        cmpr_val,
   output logic        adc_measure_done,
   output logic        sigmux,
   output logic [1:0]  refmux,
   output logic [23:0] count_up,
   output logic [23:0] count_down,
   output logic [23:0] count_rundown,
   output logic        rundown_dir,
   output logic        overflow,
   output logic        busy,
   output logic [1:0]  monitor
);

   localparam logic [23:0] RST_LAST = 24'(RESET_CLKS - 1);
   localparam logic [23:0] PH_LAST  = 24'(RUNUP_CYCLE - 1);
   localparam logic [23:0] CYC_LAST = 24'(APER_CYCLES - 1);
   localparam logic [23:0] RD_MAX   = 24'(RUNDOWN_MAX);

   localparam logic [1:0] REF_HOLD  = 2'b00;
   localparam logic [1:0] REF_POS   = 2'b01;
   localparam logic [1:0] REF_NEG   = 2'b10;
   localparam logic [1:0] REF_SHORT = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUNUP, S_RUNDOWN, S_DONE} state_t;

   state_t      state;
   logic        cmpr_m, cmpr_s;
   logic [23:0] tmr, cyc, up_cnt, dn_cnt, rd_cnt;
   logic [23:0] rd_nxt;
   logic        dir;

   assign rd_nxt  = rd_cnt + 24'd1;
   assign busy    = (state != S_IDLE);
   assign monitor = {state == S_RUNDOWN, state == S_RUNUP};

   always_ff @(posedge clk) begin
      if (reset) begin
         cmpr_m <= 1'b0;
         cmpr_s <= 1'b0;
      end else begin
         cmpr_m <= cmpr_val;
         cmpr_s <= cmpr_m;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         refmux           <= REF_SHORT;
         sigmux           <= 1'b0;
         adc_measure_done <= 1'b0;
         tmr              <= '0;
         cyc              <= '0;
         up_cnt           <= '0;
         dn_cnt           <= '0;
         rd_cnt           <= '0;
         dir              <= 1'b0;
         count_up         <= '0;
         count_down       <= '0;
         count_rundown    <= '0;
         rundown_dir      <= 1'b0;
         overflow         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               refmux           <= REF_SHORT;
               sigmux           <= 1'b0;
               adc_measure_done <= 1'b0;
               if (adc_measure_start) begin
                  state  <= S_RESET;
                  tmr    <= '0;
                  cyc    <= '0;
                  up_cnt <= '0;
                  dn_cnt <= '0;
                  rd_cnt <= '0;
               end
            end
            S_RESET: begin
               // Decision for the first run-up cycle is taken on the entry edge,
               // so refmux is already valid for its whole first clock.
               if (tmr == RST_LAST) begin
                  state  <= S_RUNUP;
                  tmr    <= '0;
                  sigmux <= 1'b1;
                  if (cmpr_s) begin
                     refmux <= REF_NEG;
                     dn_cnt <= dn_cnt + 24'd1;
                  end else begin
                     refmux <= REF_POS;
                     up_cnt <= up_cnt + 24'd1;
                  end
               end else begin
                  tmr <= tmr + 24'd1;
               end
            end
            S_RUNUP: begin
               if (tmr == PH_LAST) begin
                  tmr <= '0;
                  if (cyc == CYC_LAST) begin
                     state  <= S_RUNDOWN;
                     sigmux <= 1'b0;
                     dir    <= cmpr_s;
                     refmux <= cmpr_s ? REF_NEG : REF_POS;
                     rd_cnt <= '0;
                  end else begin
                     cyc <= cyc + 24'd1;
                     if (cmpr_s) begin
                        refmux <= REF_NEG;
                        dn_cnt <= dn_cnt + 24'd1;
                     end else begin
                        refmux <= REF_POS;
                        up_cnt <= up_cnt + 24'd1;
                     end
                  end
               end else begin
                  tmr <= tmr + 24'd1;
               end
            end
            S_RUNDOWN: begin
               // The terminating clock is itself counted; stopping at RD_MAX keeps it saturated.
               if ((cmpr_s != dir) || (rd_nxt == RD_MAX)) begin
                  state            <= S_DONE;
                  refmux           <= REF_SHORT;
                  adc_measure_done <= 1'b1;
                  count_up         <= up_cnt;
                  count_down       <= dn_cnt;
                  count_rundown    <= rd_nxt;
                  rundown_dir      <= dir;
                  overflow         <= (cmpr_s == dir);
               end else begin
                  rd_cnt <= rd_nxt;
               end
            end
            S_DONE: begin
               state            <= S_IDLE;
               refmux           <= REF_SHORT;
               sigmux           <= 1'b0;
               adc_measure_done <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               refmux <= REF_HOLD;
               sigmux <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_measure_responder.sv
// Directed bench for adc_measure_responder with small parameters; expected values hand-derived.
module tb_adc_measure_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        adc_measure_start = 1'b0;
   logic        cmpr_val = 1'b0;
   logic        adc_measure_done;
   logic        sigmux;
   logic [1:0]  refmux;
   logic [23:0] count_up, count_down, count_rundown;
   logic        rundown_dir, overflow, busy;
   logic [1:0]  monitor;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   // per-conversion observations gathered by conv()
   int k_tot, ru_clks, rd_clks, ru_pos, ru_sig;
   int snap_up, snap_dn;

   adc_measure_responder #(
      .RESET_CLKS(4), .RUNUP_CYCLE(4), .APER_CYCLES(8), .RUNDOWN_MAX(16)
   ) dut (
      .clk(clk), .reset(reset), .adc_measure_start(adc_measure_start), .cmpr_val(cmpr_val),
      .adc_measure_done(adc_measure_done), .sigmux(sigmux), .refmux(refmux),
      .count_up(count_up), .count_down(count_down), .count_rundown(count_rundown),
      .rundown_dir(rundown_dir), .overflow(overflow), .busy(busy), .monitor(monitor)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (adc_measure_done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Called at a negedge in IDLE. Pulses start, then walks negedges until done is seen.
   // tog: toggle cmpr_val every 4 clocks and pulse start twice mid-runup.
   // drop: clear cmpr_val on this rundown negedge (0 = never).
   task automatic conv(input bit tog, input int drop);
      int tc;
      bit got;
      tc = 0; got = 0;
      k_tot = 0; ru_clks = 0; rd_clks = 0; ru_pos = 0; ru_sig = 0;
      snap_up = -1; snap_dn = -1;
      adc_measure_start = 1'b1;
      while (!got && k_tot < 300) begin
         @(negedge clk);
         adc_measure_start = 1'b0;
         k_tot++;
         if (k_tot == 20) begin
            snap_up = int'(count_up);
            snap_dn = int'(count_down);
         end
         if (monitor == 2'b01) begin
            ru_clks++;
            if (refmux == 2'b01) ru_pos++;
            if (sigmux) ru_sig++;
            if (tog && (ru_clks == 5 || ru_clks == 15)) adc_measure_start = 1'b1;
         end
         if (monitor == 2'b10) begin
            rd_clks++;
            if (drop != 0 && rd_clks == drop) cmpr_val = 1'b0;
         end
         if (tog) begin
            tc++;
            if (tc == 4) begin
               cmpr_val = ~cmpr_val;
               tc = 0;
            end
         end
         if (adc_measure_done) got = 1;
      end
      check("done_timeout", int'(got), 1);
   endtask

   initial begin
      int d0;
      bit seen;
      // 1: reset with start held high
      adc_measure_start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_refmux", refmux, 3);
      check("rst_sigmux", sigmux, 0);
      check("rst_done", adc_measure_done, 0);
      check("rst_busy", busy, 0);
      check("rst_monitor", monitor, 0);
      check("rst_counts", int'(count_up | count_down | count_rundown), 0);
      check("rst_dir_ovf", {rundown_dir, overflow}, 0);
      reset = 1'b0;
      adc_measure_start = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // 2: comparator low throughout -> all +ref, rundown overflows
      conv(1'b0, 0);
      check("t2_start_to_done", k_tot, 53);
      check("t2_runup_clks", ru_clks, 32);
      check("t2_runup_refpos", ru_pos, 32);
      check("t2_runup_sig", ru_sig, 32);
      check("t2_rundown_clks", rd_clks, 16);
      check("t2_up", count_up, 8);
      check("t2_down", count_down, 0);
      check("t2_dir", rundown_dir, 0);
      check("t2_rundown", count_rundown, 16);
      check("t2_ovf", overflow, 1);
      check("t2_done_refmux", refmux, 3);
      cmpr_val = 1'b1;
      @(negedge clk);
      check("t2_done_width", adc_measure_done, 0);
      check("t2_busy_after", busy, 0);
      repeat (2) @(negedge clk);

      // 3: comparator high in runup, falls so cmpr_s flips on rundown clock 7
      conv(1'b0, 5);
      check("t3_down", count_down, 8);
      check("t3_up", count_up, 0);
      check("t3_dir", rundown_dir, 1);
      check("t3_rundown", count_rundown, 7);
      check("t3_ovf", overflow, 0);
      repeat (3) @(negedge clk);

      // 4: comparator toggled per decision cycle, stray starts mid-runup
      d0 = done_cnt;
      conv(1'b1, 0);
      check("t4_up", count_up, 4);
      check("t4_down", count_down, 4);
      check("t4_ovf", overflow, 0);
      cmpr_val = 1'b0;
      repeat (60) @(negedge clk);
      check("t4_one_done", done_cnt - d0, 1);
      check("t4_idle", busy, 0);

      // 5: reset at runup clock 10 aborts with no done
      d0 = done_cnt;
      adc_measure_start = 1'b1;
      @(negedge clk);
      adc_measure_start = 1'b0;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (monitor == 2'b01) seen = 1;
         else @(negedge clk);
      end
      check("t5_reach_runup", int'(seen), 1);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_refmux", refmux, 3);
      check("t5_sigmux", sigmux, 0);
      check("t5_busy", busy, 0);
      check("t5_cleared", int'(count_up | count_down | count_rundown), 0);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      check("t5_no_done", done_cnt - d0, 0);

      // 6: back-to-back conversions, start on the clock after done
      conv(1'b0, 0);
      check("t6a_up", count_up, 8);
      cmpr_val = 1'b1;
      @(negedge clk);
      conv(1'b0, 0);
      check("t6_held_up", snap_up, 8);
      check("t6_held_down", snap_dn, 0);
      check("t6b_down", count_down, 8);
      check("t6b_up", count_up, 0);
      check("t6b_dir", rundown_dir, 1);
      check("t6b_rundown", count_rundown, 16);
      check("t6b_ovf", overflow, 1);
      check("t6b_latency", k_tot, 53);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
